// File: rtl/axis_pattern_pkg.sv
// Shared encodings and LFSR helpers for the AXI4-Stream pattern source.
package axis_pattern_pkg;

    localparam logic [1:0]  MODE_INCR  = 2'd0;
    localparam logic [1:0]  MODE_CONST = 2'd1;
    localparam logic [1:0]  MODE_LFSR  = 2'd2;

    localparam logic [31:0] LFSR_MASK  = 32'h8020_0003;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // An all-zero state would lock the LFSR, so it is replaced by 1.
    function automatic logic [31:0] lfsr_seed_fix(input logic [31:0] seed);
        return (seed == 32'd0) ? 32'd1 : seed;
    endfunction

    // One right-shifting Galois step.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'd0);
    endfunction

endpackage

// File: rtl/axis_pattern_source_lfsr.sv
// 32-bit Galois LFSR state register with load (seed-zero guarded) and step enable.
module axis_pattern_lfsr
    import axis_pattern_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        en,
    input  logic [31:0] seed,
    output logic [31:0] value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= 32'd1;
        end else if (load) begin
            value <= lfsr_seed_fix(seed);
        end else if (en) begin
            value <= lfsr_step(value);
        end
    end

endmodule

// File: rtl/axis_pattern_source.sv
// AXI4-Stream test-pattern master: INCR/CONST(/LFSR) beats with packet TLAST framing.
// LFSR mode is built only when AXIS_PATTERN_LFSR_EN is defined; otherwise mode 2 acts as INCR.
module axis_pattern_source
    import axis_pattern_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [COUNT_W-1:0] cfg_count,
    input  logic [COUNT_W-1:0] cfg_pkt_len,
    input  logic [1:0]         cfg_mode,
    input  logic [31:0]        cfg_seed,
    output logic               M_AXIS_TVALID,
    output logic [DATA_W-1:0]  M_AXIS_TDATA,
    output logic               M_AXIS_TLAST,
    input  logic               M_AXIS_TREADY,
    output logic               busy,
    output logic               done,
    output logic               aborted
);

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] beat_q, beat_d;
    logic [COUNT_W-1:0] pkt_q, pkt_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] pkt_len_q, pkt_len_d;
    logic [1:0]         mode_q, mode_d;
    logic [DATA_W-1:0]  seed_q, seed_d;
    logic               abort_pend_q, abort_pend_d;
    logic               tvalid_q, tvalid_d;
    logic [DATA_W-1:0]  tdata_q, tdata_d;
    logic               tlast_q, tlast_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;

    logic               fire_c;
    logic [COUNT_W-1:0] beat_inc_c;
    logic [COUNT_W-1:0] pkt_inc_c;
    logic               pkt_wrap_c;
    logic               lfsr_load_c;
    logic               lfsr_en_c;

`ifdef AXIS_PATTERN_LFSR_EN
    logic [31:0]        lfsr_value;

    axis_pattern_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load_c),
        .en    (lfsr_en_c),
        .seed  (cfg_seed),
        .value (lfsr_value)
    );
`else
    logic               lfsr_unused_c;
    assign lfsr_unused_c = ^{cfg_seed, lfsr_load_c, lfsr_en_c};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            beat_q       <= '0;
            pkt_q        <= '0;
            count_q      <= '0;
            pkt_len_q    <= '0;
            mode_q       <= MODE_INCR;
            seed_q       <= '0;
            abort_pend_q <= 1'b0;
            tvalid_q     <= 1'b0;
            tdata_q      <= '0;
            tlast_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            pkt_q        <= pkt_d;
            count_q      <= count_d;
            pkt_len_q    <= pkt_len_d;
            mode_q       <= mode_d;
            seed_q       <= seed_d;
            abort_pend_q <= abort_pend_d;
            tvalid_q     <= tvalid_d;
            tdata_q      <= tdata_d;
            tlast_q      <= tlast_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
        end
    end

    // Next-state and next-beat computation; outputs hold unless a start or handshake occurs.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        pkt_d        = pkt_q;
        count_d      = count_q;
        pkt_len_d    = pkt_len_q;
        mode_d       = mode_q;
        seed_d       = seed_q;
        abort_pend_d = abort_pend_q;
        tvalid_d     = tvalid_q;
        tdata_d      = tdata_q;
        tlast_d      = tlast_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        aborted_d    = aborted_q;
        lfsr_load_c  = 1'b0;
        lfsr_en_c    = 1'b0;

        fire_c     = tvalid_q && M_AXIS_TREADY;
        beat_inc_c = beat_q + COUNT_W'(1);
        pkt_wrap_c = (pkt_len_q != '0) && (pkt_q == pkt_len_q - COUNT_W'(1));
        pkt_inc_c  = pkt_wrap_c ? '0 : pkt_q + COUNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    aborted_d = 1'b0;
                    if (cfg_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d      = ST_RUN;
                        beat_d       = '0;
                        pkt_d        = '0;
                        count_d      = cfg_count;
                        pkt_len_d    = cfg_pkt_len;
                        mode_d       = cfg_mode;
                        seed_d       = DATA_W'(cfg_seed);
                        abort_pend_d = 1'b0;
                        tvalid_d     = 1'b1;
                        busy_d       = 1'b1;
                        lfsr_load_c  = 1'b1;
                        tlast_d      = (cfg_pkt_len == COUNT_W'(1)) || (cfg_count == COUNT_W'(1));
                        case (cfg_mode)
                            MODE_CONST: tdata_d = DATA_W'(cfg_seed);
`ifdef AXIS_PATTERN_LFSR_EN
                            MODE_LFSR:  tdata_d = DATA_W'(lfsr_seed_fix(cfg_seed));
`endif
                            default:    tdata_d = DATA_W'(cfg_seed);
                        endcase
                    end
                end
            end

            ST_RUN: begin
                if (abort) begin
                    abort_pend_d = 1'b1;
                end
                if (fire_c) begin
                    // Abort lets the presented beat complete, then ends the run.
                    if (abort || abort_pend_q || (beat_q == count_q - COUNT_W'(1))) begin
                        state_d      = ST_IDLE;
                        tvalid_d     = 1'b0;
                        tlast_d      = 1'b0;
                        busy_d       = 1'b0;
                        done_d       = 1'b1;
                        aborted_d    = abort || abort_pend_q;
                        abort_pend_d = 1'b0;
                    end else begin
                        beat_d    = beat_inc_c;
                        pkt_d     = pkt_inc_c;
                        lfsr_en_c = 1'b1;
                        tlast_d   = ((pkt_len_q != '0) && (pkt_inc_c == pkt_len_q - COUNT_W'(1)))
                                    || (beat_inc_c == count_q - COUNT_W'(1));
                        case (mode_q)
                            MODE_CONST: tdata_d = seed_q;
`ifdef AXIS_PATTERN_LFSR_EN
                            MODE_LFSR:  tdata_d = DATA_W'(lfsr_step(lfsr_value));
`endif
                            default:    tdata_d = seed_q + DATA_W'(beat_inc_c);
                        endcase
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign M_AXIS_TVALID = tvalid_q;
    assign M_AXIS_TDATA  = tdata_q;
    assign M_AXIS_TLAST  = tlast_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign aborted       = aborted_q;

endmodule
